// File: rtl/operand_fetch_stage_if.sv
// Handshake and data bundle between decode, register file, writeback and execute
// for the operand fetch stage. The slave modport is the stage's own view.
interface operand_fetch_stage_if #(
  parameter int NREGS = 16,
  parameter int XLEN  = 64,
  parameter int OPW   = 8,
  parameter int CNTW  = 32,
  parameter int IDXW  = $clog2(NREGS)
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic            in_nop;
  logic [OPW-1:0]  in_op;
  logic [IDXW-1:0] in_dst_idx;
  logic [IDXW-1:0] in_src_idx;
  logic            in_src_is_reg;
  logic [XLEN-1:0] in_imm;
  logic [1:0]      in_size;
  logic            in_wr_dst;
  logic [IDXW-1:0] rf_raddr1;
  logic [IDXW-1:0] rf_raddr2;
  logic [XLEN-1:0] rf_rdata1;
  logic [XLEN-1:0] rf_rdata2;
  logic            wb_valid;
  logic [IDXW-1:0] wb_idx;
  logic [XLEN-1:0] wb_data;
  logic            out_valid;
  logic            out_ready;
  logic            out_nop;
  logic [OPW-1:0]  out_op;
  logic [IDXW-1:0] out_dst;
  logic [XLEN-1:0] out_a;
  logic [XLEN-1:0] out_b;
  logic [1:0]      out_size;
  logic [CNTW-1:0] stall_cnt;

  modport slave (
    input  flush, in_valid, in_nop, in_op, in_dst_idx, in_src_idx, in_src_is_reg,
           in_imm, in_size, in_wr_dst, rf_rdata1, rf_rdata2, wb_valid, wb_idx,
           wb_data, out_ready,
    output in_ready, rf_raddr1, rf_raddr2, out_valid, out_nop, out_op, out_dst,
           out_a, out_b, out_size, stall_cnt
  );

  modport master (
    output flush, in_valid, in_nop, in_op, in_dst_idx, in_src_idx, in_src_is_reg,
           in_imm, in_size, in_wr_dst, rf_rdata1, rf_rdata2, wb_valid, wb_idx,
           wb_data, out_ready,
    input  in_ready, rf_raddr1, rf_raddr2, out_valid, out_nop, out_op, out_dst,
           out_a, out_b, out_size, stall_cnt
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Registered operand fetch stage: register read with writeback bypass, size
// masking, busy-register scoreboard for RAW stalls, valid/ready output.
module operand_fetch_stage #(
  parameter int NREGS = 16,
  parameter int XLEN  = 64,
  parameter int OPW   = 8,
  parameter int CNTW  = 32,
  parameter int IDXW  = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 reset,
  operand_fetch_stage_if.slave bus
);

  logic [NREGS-1:0] r_busy;
  logic             r_out_valid;
  logic             r_out_nop;
  logic [OPW-1:0]   r_out_op;
  logic [IDXW-1:0]  r_out_dst;
  logic [XLEN-1:0]  r_out_a;
  logic [XLEN-1:0]  r_out_b;
  logic [1:0]       r_out_size;
  logic [CNTW-1:0]  r_stall_cnt;

  logic             w_wbhit_dst;
  logic             w_wbhit_src;
  logic [XLEN-1:0]  w_byp_dst;
  logic [XLEN-1:0]  w_byp_src;
  logic             w_hazard;
  logic             w_ready;
  logic             w_fire;
  logic [XLEN-1:0]  w_a_nxt;
  logic [XLEN-1:0]  w_b_nxt;
  logic [NREGS-1:0] w_busy_nxt;

  // Keep bits below 8<<size; sizes at or beyond XLEN leave the value intact.
  function automatic logic [XLEN-1:0] f_mask(input logic [1:0] size,
                                             input logic [XLEN-1:0] val);
    logic [XLEN-1:0] m;
    int              w;
    m = '0;
    w = 8 << size;
    for (int i = 0; i < XLEN; i++) begin
      m[i] = (i < w);
    end
    return val & m;
  endfunction

  assign bus.rf_raddr1 = bus.in_dst_idx;
  assign bus.rf_raddr2 = bus.in_src_idx;

  assign w_wbhit_dst = bus.wb_valid && (bus.wb_idx == bus.in_dst_idx);
  assign w_wbhit_src = bus.wb_valid && (bus.wb_idx == bus.in_src_idx);
  assign w_byp_dst   = w_wbhit_dst ? bus.wb_data : bus.rf_rdata1;
  assign w_byp_src   = w_wbhit_src ? bus.wb_data : bus.rf_rdata2;

  assign w_hazard = bus.in_valid && !bus.in_nop &&
                    ((r_busy[bus.in_dst_idx] && !w_wbhit_dst) ||
                     (bus.in_src_is_reg && r_busy[bus.in_src_idx] && !w_wbhit_src));
  assign w_ready  = !w_hazard && (!r_out_valid || bus.out_ready);
  assign w_fire   = bus.in_valid && w_ready;

  assign w_a_nxt = bus.in_nop ? '0 : f_mask(bus.in_size, w_byp_dst);
  assign w_b_nxt = bus.in_nop ? '0 :
                   f_mask(bus.in_size, bus.in_src_is_reg ? w_byp_src : bus.in_imm);

  // Set is applied after clear so an issuing writer wins over a retiring one.
  always_comb begin
    w_busy_nxt = r_busy;
    if (bus.wb_valid) begin
      w_busy_nxt[bus.wb_idx] = 1'b0;
    end
    if (w_fire && bus.in_wr_dst && !bus.in_nop) begin
      w_busy_nxt[bus.in_dst_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
      r_out_nop   <= 1'b0;
      r_out_op    <= '0;
      r_out_dst   <= '0;
      r_out_a     <= '0;
      r_out_b     <= '0;
      r_out_size  <= '0;
    end else if (bus.flush) begin
      r_busy      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      if (w_fire) begin
        r_out_valid <= 1'b1;
        r_out_nop   <= bus.in_nop;
        r_out_op    <= bus.in_op;
        r_out_dst   <= bus.in_dst_idx;
        r_out_a     <= w_a_nxt;
        r_out_b     <= w_b_nxt;
        r_out_size  <= bus.in_size;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != {CNTW{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNTW'(1);
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_nop   = r_out_nop;
  assign bus.out_op    = r_out_op;
  assign bus.out_dst   = r_out_dst;
  assign bus.out_a     = r_out_a;
  assign bus.out_b     = r_out_b;
  assign bus.out_size  = r_out_size;
  assign bus.stall_cnt = r_stall_cnt;

endmodule
